axi4_bram_slave: RTL

//  AXI4 (full) memory-mapped slave backed by an internal simple-dual-port block RAM.

---
 rtl/axi4_bram_slave_if.sv | 72 +++++++
 rtl/axi4_bram_slave.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/axi4_bram_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4_bram_slave_if
// Brief    : AXI4 (full) bus bundle between a burst master and the BRAM slave.
// Revision : 1.0 - initial release
// ============================================================================
interface axi4_bram_slave_if #(
   parameter int C_S_AXI_ID_WIDTH   = 1,
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 12
);
   logic [C_S_AXI_ID_WIDTH-1:0]     awid;
   logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr;
   logic [7:0]                      awlen;
   logic [2:0]                      awsize;
   logic [1:0]                      awburst;
   logic                            awvalid;
   logic                            awready;

   logic [C_S_AXI_DATA_WIDTH-1:0]   wdata;
   logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb;
   logic                            wlast;
   logic                            wvalid;
   logic                            wready;

   logic [C_S_AXI_ID_WIDTH-1:0]     bid;
   logic [1:0]                      bresp;
   logic                            bvalid;
   logic                            bready;

   logic [C_S_AXI_ID_WIDTH-1:0]     arid;
   logic [C_S_AXI_ADDR_WIDTH-1:0]   araddr;
   logic [7:0]                      arlen;
   logic [2:0]                      arsize;
   logic [1:0]                      arburst;
   logic                            arvalid;
   logic                            arready;

   logic [C_S_AXI_ID_WIDTH-1:0]     rid;
   logic [C_S_AXI_DATA_WIDTH-1:0]   rdata;
   logic [1:0]                      rresp;
   logic                            rlast;
   logic                            rvalid;
   logic                            rready;

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );
endinterface
`default_nettype wire

// File: rtl/axi4_bram_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi4_bram_slave
// Brief    : AXI4 INCR/FIXED burst slave over an internal simple-dual-port RAM.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_bram_slave #(
   parameter int C_S_AXI_ID_WIDTH   = 1,
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 12
) (
   input  wire logic         ACLK,
   input  wire logic         ARESET,
   axi4_bram_slave_if.slave  s_axi
);
   localparam int         c_idx_w  = C_S_AXI_ADDR_WIDTH - 2;
   localparam int         c_depth  = 2**c_idx_w;
   localparam int         c_strb_w = C_S_AXI_DATA_WIDTH / 8;
   localparam logic [1:0] c_okay   = 2'b00;
   localparam logic [1:0] c_slverr = 2'b10;

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
   typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} rstate_t;

   logic [C_S_AXI_DATA_WIDTH-1:0] r_mem [0:c_depth-1];

   wstate_t                       r_wstate, w_wstate_nxt;
   logic [c_idx_w-1:0]            r_widx;
   logic [7:0]                    r_wlen, r_wcnt;
   logic                          r_wfixed, r_wbad, r_wlast_err;
   logic                          r_awready, r_wready, r_bvalid;
   logic [1:0]                    r_bresp;
   logic [C_S_AXI_ID_WIDTH-1:0]   r_bid;
   logic                          w_aw_hs, w_w_hs, w_w_end, w_wlast_bad;

   rstate_t                       r_rstate, w_rstate_nxt;
   logic [c_idx_w-1:0]            r_ridx;
   logic [7:0]                    r_rlen, r_rcnt;
   logic                          r_rfixed, r_rbad;
   logic                          r_arready, r_rvalid, r_rlast;
   logic [1:0]                    r_rresp;
   logic [C_S_AXI_ID_WIDTH-1:0]   r_rid;
   logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
   logic                          w_ar_hs, w_r_hs;

   logic                          w_unused;

   // Sub-word address bits carry no meaning: every beat is treated as aligned.
   assign w_unused    = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};

   assign w_aw_hs     = r_awready & s_axi.awvalid;
   assign w_w_hs      = r_wready & s_axi.wvalid;
   assign w_w_end     = w_w_hs & (r_wcnt == r_wlen);
   assign w_wlast_bad = w_w_hs & (s_axi.wlast != (r_wcnt == r_wlen));

   always_comb begin
      w_wstate_nxt = r_wstate;
      case (r_wstate)
         W_IDLE:  if (w_aw_hs)      w_wstate_nxt = W_DATA;
         W_DATA:  if (w_w_end)      w_wstate_nxt = W_RESP;
         W_RESP:  if (s_axi.bready) w_wstate_nxt = W_IDLE;
         default:                   w_wstate_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_wstate    <= W_IDLE;
         r_awready   <= 1'b0;
         r_wready    <= 1'b0;
         r_bvalid    <= 1'b0;
         r_bresp     <= c_okay;
         r_bid       <= '0;
         r_widx      <= '0;
         r_wlen      <= '0;
         r_wcnt      <= '0;
         r_wfixed    <= 1'b0;
         r_wbad      <= 1'b0;
         r_wlast_err <= 1'b0;
      end else begin
         r_wstate  <= w_wstate_nxt;
         r_awready <= (w_wstate_nxt == W_IDLE);
         r_wready  <= (w_wstate_nxt == W_DATA);
         r_bvalid  <= (w_wstate_nxt == W_RESP);
         if (w_aw_hs) begin
            r_bid       <= s_axi.awid;
            r_widx      <= s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
            r_wlen      <= s_axi.awlen;
            r_wcnt      <= '0;
            r_wfixed    <= (s_axi.awburst == 2'b00);
            r_wbad      <= (s_axi.awsize != 3'd2) | s_axi.awburst[1];
            r_wlast_err <= 1'b0;
         end
         if (w_w_hs) begin
            r_wcnt <= r_wcnt + 8'd1;
            if (!r_wfixed) r_widx <= r_widx + 1'b1;
            if (w_wlast_bad) r_wlast_err <= 1'b1;
         end
         if (w_w_end)
            r_bresp <= (r_wbad | r_wlast_err | w_wlast_bad) ? c_slverr : c_okay;
      end
   end

   // Unsupported bursts still consume their beats but never touch the RAM.
   always_ff @(posedge ACLK) begin
      if (!ARESET && w_w_hs && !r_wbad) begin
         for (int b = 0; b < c_strb_w; b++) begin
            if (s_axi.wstrb[b]) r_mem[r_widx][8*b +: 8] <= s_axi.wdata[8*b +: 8];
         end
      end
   end

   assign w_ar_hs = r_arready & s_axi.arvalid;
   assign w_r_hs  = r_rvalid & s_axi.rready;

   always_comb begin
      w_rstate_nxt = r_rstate;
      case (r_rstate)
         R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_FETCH;
         R_FETCH:              w_rstate_nxt = R_DATA;
         R_DATA:  if (w_r_hs)  w_rstate_nxt = r_rlast ? R_IDLE : R_FETCH;
         default:              w_rstate_nxt = R_IDLE;
      endcase
   end

   // The RAM output register doubles as RDATA, so it only loads in R_FETCH
   // and stays frozen while a beat waits for RREADY.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_rstate  <= R_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rlast   <= 1'b0;
         r_rresp   <= c_okay;
         r_rid     <= '0;
         r_rdata   <= '0;
         r_ridx    <= '0;
         r_rlen    <= '0;
         r_rcnt    <= '0;
         r_rfixed  <= 1'b0;
         r_rbad    <= 1'b0;
      end else begin
         r_rstate  <= w_rstate_nxt;
         r_arready <= (w_rstate_nxt == R_IDLE);
         r_rvalid  <= (w_rstate_nxt == R_DATA);
         if (w_ar_hs) begin
            r_rid    <= s_axi.arid;
            r_ridx   <= s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
            r_rlen   <= s_axi.arlen;
            r_rcnt   <= '0;
            r_rfixed <= (s_axi.arburst == 2'b00);
            r_rbad   <= (s_axi.arsize != 3'd2) | s_axi.arburst[1];
         end
         if (r_rstate == R_FETCH) begin
            r_rdata <= r_rbad ? '0 : r_mem[r_ridx];
            r_rresp <= r_rbad ? c_slverr : c_okay;
            r_rlast <= (r_rcnt == r_rlen);
         end
         if (w_r_hs) begin
            r_rcnt  <= r_rcnt + 8'd1;
            r_rlast <= 1'b0;
            if (!r_rfixed) r_ridx <= r_ridx + 1'b1;
         end
      end
   end

   assign s_axi.awready = r_awready;
   assign s_axi.wready  = r_wready;
   assign s_axi.bvalid  = r_bvalid;
   assign s_axi.bresp   = r_bresp;
   assign s_axi.bid     = r_bid;
   assign s_axi.arready = r_arready;
   assign s_axi.rvalid  = r_rvalid;
   assign s_axi.rdata   = r_rdata;
   assign s_axi.rresp   = r_rresp;
   assign s_axi.rlast   = r_rlast;
   assign s_axi.rid     = r_rid;
endmodule
`default_nettype wire
